// File: rtl/pong_pkg.sv
// Shared screen geometry, ball state encoding and direction codes for the pong datapath.
package pong_pkg;

  localparam int unsigned POS_W   = 11;
  localparam int unsigned H_MAX   = 799;
  localparam int unsigned V_MAX   = 474;
  localparam int unsigned NET_H   = 390;
  localparam int unsigned V_SERVE = 237;
  localparam int unsigned L_PAD_X = 10;
  localparam int unsigned R_PAD_X = 780;
  localparam int unsigned PAD_LEN = 80;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } ball_state_t;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Paddle POSITION codes carry the top row at 2-px resolution.
  function automatic logic [POS_W-1:0] paddle_top(input logic [7:0] pos);
    return {3'b000, pos, 1'b0};
  endfunction

endpackage

// File: rtl/move_tick.sv
// Free-running prescaler: one-cycle TICK every TICK_DIV enabled clocks; holds while disabled.
module move_tick #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic ENABLE,
  output logic TICK
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Count 0..TICK_DIV-1 while enabled, wrapping on the tick cycle
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (ENABLE) begin
      if (cnt == CNT_LAST) cnt <= '0;
      else                 cnt <= cnt + CNT_ONE;
    end
  end

  assign TICK = ENABLE && (cnt == CNT_LAST);

endmodule

// File: rtl/ball_motion.sv
// Pong ball: steps one pixel per axis per move tick, bounces off walls and paddles,
// detects misses and runs the serve/score cycle.
module ball_motion #(
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned SERVE_TICKS = 100,
  parameter int unsigned H_MAX       = pong_pkg::H_MAX,
  parameter int unsigned V_MAX       = pong_pkg::V_MAX,
  parameter int unsigned NET_H       = pong_pkg::NET_H,
  parameter int unsigned V_SERVE     = pong_pkg::V_SERVE,
  parameter int unsigned L_PAD_X     = pong_pkg::L_PAD_X,
  parameter int unsigned R_PAD_X     = pong_pkg::R_PAD_X,
  parameter int unsigned PAD_LEN     = pong_pkg::PAD_LEN
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        PAUSE,
  input  logic [7:0]  PLAYER_POS,
  input  logic [7:0]  AI_POS,
  output logic [10:0] BALL_H,
  output logic [10:0] BALL_V,
  output logic        HIT,
  output logic        SCORE_L,
  output logic        SCORE_R
);

  import pong_pkg::*;

  localparam int unsigned SC_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [SC_W-1:0]  SERVE_LAST = SC_W'(SERVE_TICKS - 1);
  localparam logic [SC_W-1:0]  SC_ONE     = SC_W'(1);
  localparam logic [POS_W-1:0] H_LAST     = POS_W'(H_MAX);
  localparam logic [POS_W-1:0] V_LAST     = POS_W'(V_MAX);
  localparam logic [POS_W-1:0] H_HOME     = POS_W'(NET_H);
  localparam logic [POS_W-1:0] V_HOME     = POS_W'(V_SERVE);
  localparam logic [POS_W-1:0] L_HIT_H    = POS_W'(L_PAD_X + 1);
  localparam logic [POS_W-1:0] R_HIT_H    = POS_W'(R_PAD_X - 1);
  localparam logic [POS_W-1:0] PAD_SPAN   = POS_W'(PAD_LEN - 1);
  localparam logic [POS_W-1:0] ONE        = POS_W'(1);

  logic              tick;
  ball_state_t       state, state_nxt;
  logic [POS_W-1:0]  ball_h, ball_v, h_nxt, v_nxt;
  logic              dir_h, dir_v, dh_nxt, dv_nxt;
  logic [SC_W-1:0]   serve_cnt, scnt_nxt;
  logic              hit_nxt, sl_nxt, sr_nxt;
  logic [POS_W-1:0]  top_l, top_r;
  logic              in_l, in_r;
  logic              l_bounce, r_bounce, l_miss, r_miss;

  move_tick #(.TICK_DIV(TICK_DIV)) u_move_tick (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .ENABLE  (!PAUSE),
    .TICK    (tick)
  );

  // Paddle windows against the current (pre-update) row; only acted on during a tick.
  assign top_l = paddle_top(PLAYER_POS);
  assign top_r = paddle_top(AI_POS);
  assign in_l  = (ball_v >= top_l) && (ball_v <= top_l + PAD_SPAN);
  assign in_r  = (ball_v >= top_r) && (ball_v <= top_r + PAD_SPAN);

  // A paddle only reflects from the column just in front of it; otherwise the ball
  // carries on through the paddle column and is lost at the screen edge.
  assign r_bounce = (dir_h == DIR_RIGHT) && (ball_h == R_HIT_H) && in_r;
  assign l_bounce = (dir_h == DIR_LEFT)  && (ball_h == L_HIT_H) && in_l;
  assign r_miss   = (dir_h == DIR_RIGHT) && !r_bounce && (ball_h == H_LAST);
  assign l_miss   = (dir_h == DIR_LEFT)  && !l_bounce && (ball_h == '0);

  // State, position, direction, serve count and event pulses
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= SERVE;
      ball_h    <= H_HOME;
      ball_v    <= V_HOME;
      dir_h     <= DIR_RIGHT;
      dir_v     <= DIR_DOWN;
      serve_cnt <= '0;
      HIT       <= 1'b0;
      SCORE_L   <= 1'b0;
      SCORE_R   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ball_h    <= h_nxt;
      ball_v    <= v_nxt;
      dir_h     <= dh_nxt;
      dir_v     <= dv_nxt;
      serve_cnt <= scnt_nxt;
      HIT       <= hit_nxt;
      SCORE_L   <= sl_nxt;
      SCORE_R   <= sr_nxt;
    end
  end

  // Next state: rest for SERVE_TICKS ticks, play until an edge is reached, one-cycle MISS
  always_comb begin
    state_nxt = state;
    unique case (state)
      SERVE:   if (tick && (serve_cnt == SERVE_LAST)) state_nxt = PLAY;
      PLAY:    if (tick && (r_miss || l_miss))        state_nxt = MISS;
      MISS:    state_nxt = SERVE;
      default: state_nxt = SERVE;
    endcase
  end

  // Next position, direction, serve count and pulses for each state
  always_comb begin
    h_nxt    = ball_h;
    v_nxt    = ball_v;
    dh_nxt   = dir_h;
    dv_nxt   = dir_v;
    scnt_nxt = serve_cnt;
    hit_nxt  = 1'b0;
    sl_nxt   = 1'b0;
    sr_nxt   = 1'b0;
    unique case (state)
      SERVE: begin
        if (tick) scnt_nxt = (serve_cnt == SERVE_LAST) ? '0 : serve_cnt + SC_ONE;
      end
      PLAY: begin
        if (tick) begin
          if ((dir_v == DIR_DOWN) && (ball_v == V_LAST)) begin
            dv_nxt = DIR_UP;
            v_nxt  = ball_v - ONE;
          end else if ((dir_v == DIR_UP) && (ball_v == '0)) begin
            dv_nxt = DIR_DOWN;
            v_nxt  = ball_v + ONE;
          end else if (dir_v == DIR_DOWN) begin
            v_nxt  = ball_v + ONE;
          end else begin
            v_nxt  = ball_v - ONE;
          end

          if (r_bounce) begin
            dh_nxt  = DIR_LEFT;
            h_nxt   = ball_h - ONE;
            hit_nxt = 1'b1;
          end else if (l_bounce) begin
            dh_nxt  = DIR_RIGHT;
            h_nxt   = ball_h + ONE;
            hit_nxt = 1'b1;
          end else if (r_miss || l_miss) begin
            h_nxt   = ball_h;
          end else if (dir_h == DIR_RIGHT) begin
            h_nxt   = ball_h + ONE;
          end else begin
            h_nxt   = ball_h - ONE;
          end
        end
      end
      MISS: begin
        // dir_h still points at the side that conceded, which is also where the
        // next serve must travel, so it is left as is.
        h_nxt  = H_HOME;
        v_nxt  = V_HOME;
        sl_nxt = (dir_h == DIR_RIGHT);
        sr_nxt = (dir_h == DIR_LEFT);
      end
      default: begin
        h_nxt = H_HOME;
        v_nxt = V_HOME;
      end
    endcase
  end

  assign BALL_H = ball_h;
  assign BALL_V = ball_v;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: expected position/pulse events are queued with the
// cycle (counted from reset release) at which they must appear; a monitor pops one
// entry for every cycle in which the ball moves or a pulse is high.
module tb_ball_motion;

  typedef struct {
    int cyc;
    int h;
    int v;
    bit hit;
    bit sl;
    bit sr;
  } evt_t;

  localparam int TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        pause [2];
  logic [7:0]  ppos  [2];
  logic [7:0]  apos  [2];
  logic [10:0] bh    [2];
  logic [10:0] bv    [2];
  logic        hit_o [2];
  logic        sl_o  [2];
  logic        sr_o  [2];

  int cyc    [2];
  int prev_h [2];
  int prev_v [2];
  int vhome  [2] = '{237, 85};

  evt_t q0[$];
  evt_t q1[$];
  evt_t got, want;
  int   qn;

  int total = 0;
  int bad   = 0;

  ball_motion #(.TICK_DIV(TD), .SERVE_TICKS(3)) u_dut (
    .CLOCK(clk), .RESET_N(rst_n[0]), .PAUSE(pause[0]), .PLAYER_POS(ppos[0]), .AI_POS(apos[0]),
    .BALL_H(bh[0]), .BALL_V(bv[0]), .HIT(hit_o[0]), .SCORE_L(sl_o[0]), .SCORE_R(sr_o[0])
  );

  ball_motion #(.TICK_DIV(TD), .SERVE_TICKS(3), .V_SERVE(85)) u_corner (
    .CLOCK(clk), .RESET_N(rst_n[1]), .PAUSE(pause[1]), .PLAYER_POS(ppos[1]), .AI_POS(apos[1]),
    .BALL_H(bh[1]), .BALL_V(bv[1]), .HIT(hit_o[1]), .SCORE_L(sl_o[1]), .SCORE_R(sr_o[1])
  );

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) cyc[i] <= (rst_n[i] === 1'b1) ? cyc[i] + 1 : 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n[i] !== 1'b1) begin
        prev_h[i] = 390;
        prev_v[i] = vhome[i];
      end else if (int'(bh[i]) != prev_h[i] || int'(bv[i]) != prev_v[i] ||
                   hit_o[i] || sl_o[i] || sr_o[i]) begin
        got.cyc = cyc[i];
        got.h   = int'(bh[i]);
        got.v   = int'(bv[i]);
        got.hit = hit_o[i];
        got.sl  = sl_o[i];
        got.sr  = sr_o[i];
        prev_h[i] = got.h;
        prev_v[i] = got.v;
        total++;
        qn = (i == 0) ? q0.size() : q1.size();
        if (qn == 0) begin
          bad++;
          $display("FAIL unexpected_evt dut%0d: got cyc=%0d h=%0d v=%0d hit=%0b sl=%0b sr=%0b, expected no event",
                   i, got.cyc, got.h, got.v, got.hit, got.sl, got.sr);
        end else begin
          if (i == 0) want = q0.pop_front();
          else        want = q1.pop_front();
          if (got.cyc != want.cyc || got.h != want.h || got.v != want.v ||
              got.hit != want.hit || got.sl != want.sl || got.sr != want.sr) begin
            bad++;
            $display("FAIL evt dut%0d: got cyc=%0d h=%0d v=%0d hit=%0b sl=%0b sr=%0b, want cyc=%0d h=%0d v=%0d hit=%0b sl=%0b sr=%0b",
                     i, got.cyc, got.h, got.v, got.hit, got.sl, got.sr,
                     want.cyc, want.h, want.v, want.hit, want.sl, want.sr);
          end
        end
      end
    end
  end

  task automatic push(input int i, input int c, input int h, input int v,
                      input bit hit, input bit sl, input bit sr);
    evt_t e;
    e.cyc = c; e.h = h; e.v = v; e.hit = hit; e.sl = sl; e.sr = sr;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // n plain moves, one per tick, along a straight diagonal
  task automatic push_seg(input int i, input int c0, input int h0, input int dh,
                          input int v0, input int dv, input int n);
    for (int k = 0; k < n; k++) push(i, c0 + TD * k, h0 + dh * k, v0 + dv * k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int i, input int target);
    int guard;
    guard = 0;
    while (cyc[i] < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc[i] != target) begin
      total++;
      bad++;
      $display("FAIL wait_dut%0d: reached cycle %0d, want %0d", i, cyc[i], target);
    end
  endtask

  task automatic chk_reset(input int i, input string tag);
    chk({tag, "_h"},   int'(bh[i]), 390);
    chk({tag, "_v"},   int'(bv[i]), vhome[i]);
    chk({tag, "_hit"}, int'(hit_o[i]), 0);
    chk({tag, "_sl"},  int'(sl_o[i]), 0);
    chk({tag, "_sr"},  int'(sr_o[i]), 0);
  endtask

  task automatic release_rst(input int i);
    repeat (2) @(negedge clk);
    #1 rst_n[i] = 1'b1;
  endtask

  task automatic assert_rst(input int i, input string tag);
    #1 rst_n[i] = 1'b0;
    #1 chk_reset(i, tag);
    chk({tag, "_drained"}, (i == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    pause[0] = 1'b0; pause[1] = 1'b0;
    ppos[0]  = 8'd0; ppos[1]  = 8'd0;
    apos[0]  = 8'd130;           // right paddle rows 260..339
    apos[1]  = 8'd160;           // right paddle rows 320..399
    repeat (3) @(negedge clk);
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");

    // Main rally: moves at tick 4,8,... after release; tick k lands on cycle 4k,
    // shifted by 40 once the 40-cycle pause has been taken.
    push_seg(0, 16,   391,  1, 238,  1, 4);     // t=1..4
    push_seg(0, 72,   395,  1, 242,  1, 233);   // t=5..237, reaches floor V=474
    push_seg(0, 1004, 628,  1, 473, -1, 152);   // t=238..389, ends at H=779 V=322
    push(0, 1612, 778, 321, 1'b1, 1'b0, 1'b0);  // AI paddle reflection
    push_seg(0, 1616, 777, -1, 320, -1, 321);   // up to the ceiling V=0 at H=457
    push_seg(0, 2900, 456, -1, 1,    1, 457);   // through player column to H=0 V=457
    push(0, 4728, 0,   458, 1'b0, 1'b0, 1'b0);  // edge tick: H holds, V still steps
    push(0, 4729, 390, 237, 1'b0, 1'b0, 1'b1);  // AI scores, ball recentred
    push_seg(0, 4744, 389, -1, 238, 1, 3);      // serve goes left, still downward
    release_rst(0);
    wait_cyc(0, 30);
    #1 pause[0] = 1'b1;
    wait_cyc(0, 70);
    #1 pause[0] = 1'b0;
    wait_cyc(0, 4754);
    assert_rst(0, "midrally0");

    // Serve row 85 puts the ball on the floor exactly at H=779: paddle misses the corner.
    push_seg(1, 16,   391, 1, 86,  1, 389);     // t=1..389, ends at H=779 V=474
    push(1, 1572, 780, 473, 1'b0, 1'b0, 1'b0);  // vertical reflection only
    push_seg(1, 1576, 781, 1, 472, -1, 19);     // on to H=799 V=454
    push(1, 1652, 799, 453, 1'b0, 1'b0, 1'b0);
    push(1, 1653, 390, 85,  1'b0, 1'b1, 1'b0);  // player scores
    push(1, 1668, 391, 84,  1'b0, 1'b0, 1'b0);  // serve goes right, still upward
    release_rst(1);
    wait_cyc(1, 1670);
    assert_rst(1, "corner_miss");

    // Same corner with the paddle covering rows 400..479: both reflections at once.
    apos[1] = 8'd200;
    push_seg(1, 16,   391, 1, 86, 1, 389);
    push(1, 1572, 778, 473, 1'b1, 1'b0, 1'b0);
    push(1, 1576, 777, 472, 1'b0, 1'b0, 1'b0);
    release_rst(1);
    wait_cyc(1, 1578);
    assert_rst(1, "corner_hit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
